pipeline_controller: RTL and testbench
======================================

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, max consecutive MEM_WAIT cycles before the timeout flag sets.
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port src1  input  4  ID-stage first source register address.
REQ-006 SHALL have port src2  input  4  ID-stage second source register address.
REQ-007 SHALL have port two_src  input  1  ID instruction uses src2.
REQ-008 SHALL have ports ex_dest  input  4 and ex_wb_en  input  1  EX-stage destination and its writeback enable.
REQ-009 SHALL have ports mem_dest  input  4 and mem_wb_en  input  1  MEM-stage destination and its writeback enable.
REQ-010 SHALL have port branch_taken_ex  input  1  branch resolved taken in EX.
REQ-011 SHALL have ports mem_req  input  1 and mem_ready  input  1  MEM-stage access active and memory ready.
REQ-012 SHALL have port freeze  output  1  hold the IF stage and IF/ID register.
REQ-013 SHALL have port flush  output  1  clear the IF/ID and ID/EX registers.
REQ-014 SHALL have port id_bubble  output  1  load a NOP into the ID/EX register.
REQ-015 SHALL have port pipe_hold  output  1  hold every pipeline stage.
REQ-016 SHALL have port mem_timeout  output  1  sticky flag: memory wait exceeded MEM_TIMEOUT.
REQ-017 SHALL have port state  output  2  current FSM state.

Function
REQ-018 Data hazard SHALL be hazard = (ex_wb_en & ex_dest==src1) | (ex_wb_en & two_src & ex_dest==src2) | (mem_wb_en & mem_dest==src1) | (mem_wb_en & two_src & mem_dest==src2); src2 is ignored when two_src=0.
REQ-019 FSM states SHALL be RUN=2'b00, HAZ=2'b01, FLUSH=2'b10, MEMW=2'b11.
REQ-020 Same-cycle event priority SHALL be memory wait (mem_req & !mem_ready), then branch_taken_ex, then hazard.
REQ-021 Control outputs SHALL be combinational in state and current inputs, with zero-cycle latency.
REQ-022 Memory wait SHALL give pipe_hold=1, freeze=0, flush=0 and id_bubble=0; next state MEMW; MEMW stays until mem_ready=1, then returns to RUN.
REQ-023 Taken branch without memory wait SHALL give flush=1 for exactly that cycle; next state FLUSH.
REQ-024 The FLUSH state SHALL suppress hazard for one cycle, then return to RUN unless a new event occurs.
REQ-025 Hazard without a higher-priority event SHALL give freeze=1 and id_bubble=1 while the hazard persists; the state is HAZ, and it returns to RUN the cycle the hazard clears.
REQ-026 branch_taken_ex asserted in HAZ SHALL override: flush=1, freeze=0, id_bubble=0.
REQ-027 A wait counter SHALL reset to 0 on MEMW entry and increment each MEMW cycle, saturating.
REQ-028 When the wait counter reaches MEM_TIMEOUT, mem_timeout SHALL set and remain set until reset; pipe_hold stays asserted while waiting.
REQ-029 No two of pipe_hold, flush and freeze SHALL be asserted in the same cycle.

Reset
REQ-030 While rst=0, the block SHALL hold state=RUN, force all control outputs to 0, and clear mem_timeout, the wait counter and stall_count.
REQ-031 Reset asserted mid-MEMW or mid-HAZ SHALL take effect immediately and asynchronously.
REQ-032 After reset release, the first edge SHALL evaluate inputs from RUN.

Configuration
REQ-033 With macro PIPE_STALL_COUNT_EN defined, an output stall_count[CNT_W-1:0] SHALL exist, incrementing on every cycle where freeze or pipe_hold is 1 and saturating at all-ones.
REQ-034 Without PIPE_STALL_COUNT_EN, the stall_count port and its logic SHALL be absent, with all other behaviour unchanged.

Verification
REQ-035 Bench SHALL cover: ex_wb_en=1, ex_dest=4'd3, src1=4'd3 for 1 cycle -> freeze=1, id_bubble=1, state=HAZ; next cycle with no match -> RUN, outputs 0.
REQ-036 Bench SHALL cover: two_src=0, src2=4'd5, mem_dest=4'd5, mem_wb_en=1 -> no stall; two_src=1 -> freeze=1.
REQ-037 Bench SHALL cover: hazard active and branch_taken_ex=1 same cycle -> flush=1, freeze=0; next cycle with hazard still true -> state=FLUSH, freeze=0.
REQ-038 Bench SHALL cover: mem_req=1, mem_ready=0 for 3 cycles, branch_taken_ex=1 concurrently -> pipe_hold=1 and flush=0 for 3 cycles; mem_ready=1 -> RUN.
REQ-039 Bench SHALL cover: MEM_TIMEOUT=4, mem_ready=0 for 6 cycles -> mem_timeout=1 from the 4th MEMW cycle; it stays 1 after mem_ready=1 until rst=0.
REQ-040 Bench SHALL cover: PIPE_STALL_COUNT_EN defined, 2 hazard cycles plus 3 wait cycles -> stall_count=5; rst=0 mid-MEMW -> stall_count=0 and state=RUN immediately.

Source files
------------

// File: rtl/pipeline_controller.sv
// Hazard/flush/memory-wait controller for a 5-stage in-order pipeline.
// Define PIPE_STALL_COUNT_EN to add the saturating stall_count output.
module pipeline_controller #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] src1,
   input  logic [3:0] src2,
   input  logic       two_src,
   input  logic [3:0] ex_dest,
   input  logic       ex_wb_en,
   input  logic [3:0] mem_dest,
   input  logic       mem_wb_en,
   input  logic       branch_taken_ex,
   input  logic       mem_req,
   input  logic       mem_ready,
   output logic       freeze,
   output logic       flush,
   output logic       id_bubble,
   output logic       pipe_hold,
   output logic       mem_timeout,
   output logic [1:0] state
`ifdef PIPE_STALL_COUNT_EN
   ,
   output logic [CNT_W-1:0] stall_count
`endif
);

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      HAZ   = 2'b01,
      FLUSH = 2'b10,
      MEMW  = 2'b11
   } state_e;

   localparam int WCW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WCW-1:0] WC_MAX = WCW'(MEM_TIMEOUT);
   localparam logic [WCW-1:0] WC_HIT = WCW'((MEM_TIMEOUT < 1) ? 0 : MEM_TIMEOUT - 1);

   state_e         state_q, state_d;
   logic [WCW-1:0] wcnt_q, wcnt_d;
   logic           tout_q, tout_d;
   logic           hazard, mem_wait, to_hit;
   logic           fz, fl, bb, ph;

   assign mem_wait = mem_req & ~mem_ready;

   assign hazard = (ex_wb_en  & (ex_dest  == src1))
                 | (ex_wb_en  & two_src & (ex_dest  == src2))
                 | (mem_wb_en & (mem_dest == src1))
                 | (mem_wb_en & two_src & (mem_dest == src2));

   always_comb begin
      state_d = state_q;
      fz = 1'b0;
      fl = 1'b0;
      bb = 1'b0;
      ph = 1'b0;
      case (state_q)
         MEMW: begin
            if (mem_ready) begin
               state_d = RUN;
            end else begin
               ph = 1'b1;
            end
         end
         default: begin
            // Priority: memory wait, then taken branch, then data hazard.
            if (mem_wait) begin
               ph      = 1'b1;
               state_d = MEMW;
            end else if (branch_taken_ex) begin
               fl      = 1'b1;
               state_d = FLUSH;
            end else if (hazard && (state_q != FLUSH)) begin
               fz      = 1'b1;
               bb      = 1'b1;
               state_d = HAZ;
            end else begin
               state_d = RUN;
            end
         end
      endcase
   end

   // wcnt_q holds completed MEMW cycles, so the current one is wcnt_q + 1.
   assign to_hit = (state_q == MEMW) && (wcnt_q >= WC_HIT);

   always_comb begin
      wcnt_d = '0;
      if (state_q == MEMW) begin
         wcnt_d = (wcnt_q == WC_MAX) ? wcnt_q : wcnt_q + 1'b1;
      end
      tout_d = tout_q | to_hit;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         wcnt_q  <= '0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         tout_q  <= tout_d;
      end
   end

   assign freeze      = rst & fz;
   assign flush       = rst & fl;
   assign id_bubble   = rst & bb;
   assign pipe_hold   = rst & ph;
   assign mem_timeout = rst & (tout_q | to_hit);
   assign state       = state_q;

`ifdef PIPE_STALL_COUNT_EN
   logic [CNT_W-1:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((fz | ph) && !(&stall_q)) begin
         stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Randomised + directed bench for pipeline_controller against a
// rule-level reference model; MEM_TIMEOUT is set to 4.
module tb_pipeline_controller;

   localparam int TO    = 4;
   localparam int CW    = 16;
   localparam int STMAX = (1 << CW) - 1;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] src1, src2, ex_dest, mem_dest;
   logic       two_src, ex_wb_en, mem_wb_en;
   logic       branch_taken_ex, mem_req, mem_ready;
   logic       freeze, flush, id_bubble, pipe_hold, mem_timeout;
   logic [1:0] state;
`ifdef PIPE_STALL_COUNT_EN
   logic [CW-1:0] stall_count;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   pipeline_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk),
      .rst(rst),
      .src1(src1),
      .src2(src2),
      .two_src(two_src),
      .ex_dest(ex_dest),
      .ex_wb_en(ex_wb_en),
      .mem_dest(mem_dest),
      .mem_wb_en(mem_wb_en),
      .branch_taken_ex(branch_taken_ex),
      .mem_req(mem_req),
      .mem_ready(mem_ready),
      .freeze(freeze),
      .flush(flush),
      .id_bubble(id_bubble),
      .pipe_hold(pipe_hold),
      .mem_timeout(mem_timeout),
      .state(state)
`ifdef PIPE_STALL_COUNT_EN
      ,
      .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: mode uses the spec's state numbering directly.
   int m_mode, m_wc, m_st;
   bit m_to;
   bit e_haz, e_fz, e_fl, e_bb, e_ph, e_to;
   int e_nxt;

   always_comb begin
      e_haz = 1'b0;
      if (ex_wb_en && (ex_dest == src1 || (two_src && ex_dest == src2)))
         e_haz = 1'b1;
      if (mem_wb_en && (mem_dest == src1 || (two_src && mem_dest == src2)))
         e_haz = 1'b1;
      e_fz = 1'b0;
      e_fl = 1'b0;
      e_bb = 1'b0;
      e_ph = 1'b0;
      e_nxt = 0;
      if (m_mode == 3) begin
         if (!mem_ready) begin
            e_ph = 1'b1;
            e_nxt = 3;
         end
      end else if (mem_req && !mem_ready) begin
         e_ph = 1'b1;
         e_nxt = 3;
      end else if (branch_taken_ex) begin
         e_fl = 1'b1;
         e_nxt = 2;
      end else if (e_haz && m_mode != 2) begin
         e_fz = 1'b1;
         e_bb = 1'b1;
         e_nxt = 1;
      end
      e_to = m_to || (m_mode == 3 && (m_wc + 1) >= TO);
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_mode <= 0;
         m_wc   <= 0;
         m_to   <= 1'b0;
         m_st   <= 0;
      end else begin
         m_mode <= e_nxt;
         m_wc   <= (m_mode == 3) ? m_wc + 1 : 0;
         m_to   <= e_to;
         if (e_fz || e_ph)
            m_st <= (m_st >= STMAX) ? STMAX : m_st + 1;
      end
   end

   task automatic cmp(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp("m_freeze", int'(freeze), int'(rst & e_fz));
         cmp("m_flush", int'(flush), int'(rst & e_fl));
         cmp("m_bubble", int'(id_bubble), int'(rst & e_bb));
         cmp("m_hold", int'(pipe_hold), int'(rst & e_ph));
         cmp("m_timeout", int'(mem_timeout), int'(rst & e_to));
         cmp("m_state", int'(state), rst ? m_mode : 0);
         cmp("m_excl", int'((int'(freeze) + int'(flush) + int'(pipe_hold)) <= 1), 1);
`ifdef PIPE_STALL_COUNT_EN
         cmp("m_stall", int'(stall_count), m_st);
`endif
      end
   end

   task automatic clr();
      src1 = 4'd0;
      src2 = 4'd0;
      two_src = 1'b0;
      ex_dest = 4'd0;
      ex_wb_en = 1'b0;
      mem_dest = 4'd0;
      mem_wb_en = 1'b0;
      branch_taken_ex = 1'b0;
      mem_req = 1'b0;
      mem_ready = 1'b0;
   endtask

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr();
      ex_wb_en = 1'b1;
      ex_dest = 4'd3;
      src1 = 4'd3;
      mem_req = 1'b1;
      branch_taken_ex = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      cmp("rst_state", int'(state), 0);
      cmp("rst_freeze", int'(freeze), 0);
      cmp("rst_flush", int'(flush), 0);
      cmp("rst_hold", int'(pipe_hold), 0);
      clr();
      #2 rst = 1'b1;
      go();

      // single-cycle EX hazard on src1
      ex_wb_en = 1'b1;
      ex_dest = 4'd3;
      src1 = 4'd3;
      @(negedge clk);
      cmp("haz_freeze", int'(freeze), 1);
      cmp("haz_bubble", int'(id_bubble), 1);
      go();
      clr();
      @(negedge clk);
      cmp("haz_state", int'(state), 1);
      cmp("haz_clr_freeze", int'(freeze), 0);
      go();
      @(negedge clk);
      cmp("haz_back_run", int'(state), 0);
      go();

      // src2 only matters when two_src=1
      clr();
      src1 = 4'd9;
      src2 = 4'd5;
      mem_dest = 4'd5;
      mem_wb_en = 1'b1;
      @(negedge clk);
      cmp("one_src_freeze", int'(freeze), 0);
      go();
      two_src = 1'b1;
      @(negedge clk);
      cmp("two_src_freeze", int'(freeze), 1);
      go();
      clr();
      go();

      // branch overrides hazard, FLUSH then suppresses it
      ex_wb_en = 1'b1;
      ex_dest = 4'd3;
      src1 = 4'd3;
      branch_taken_ex = 1'b1;
      @(negedge clk);
      cmp("br_flush", int'(flush), 1);
      cmp("br_freeze", int'(freeze), 0);
      go();
      branch_taken_ex = 1'b0;
      @(negedge clk);
      cmp("fl_state", int'(state), 2);
      cmp("fl_freeze", int'(freeze), 0);
      cmp("fl_flush", int'(flush), 0);
      go();
      @(negedge clk);
      cmp("fl_after_freeze", int'(freeze), 1);
      go();
      clr();
      go();

      // memory wait beats a concurrent branch
      mem_req = 1'b1;
      branch_taken_ex = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         cmp("mw_hold", int'(pipe_hold), 1);
         cmp("mw_flush", int'(flush), 0);
         go();
      end
      mem_ready = 1'b1;
      branch_taken_ex = 1'b0;
      @(negedge clk);
      cmp("mw_rdy_state", int'(state), 3);
      cmp("mw_rdy_hold", int'(pipe_hold), 0);
      go();
      clr();
      @(negedge clk);
      cmp("mw_run", int'(state), 0);
      cmp("mw_no_to", int'(mem_timeout), 0);
      go();

      // timeout sets on the 4th MEMW cycle and is sticky
      mem_req = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         cmp("to_hold", int'(pipe_hold), 1);
         cmp("to_flag", int'(mem_timeout), (k >= 5) ? 1 : 0);
         go();
      end
      mem_ready = 1'b1;
      @(negedge clk);
      cmp("to_rdy", int'(mem_timeout), 1);
      go();
      clr();
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         cmp("to_sticky", int'(mem_timeout), 1);
         go();
      end
      #2 rst = 1'b0;
      #1;
      cmp("to_rst", int'(mem_timeout), 0);
      #3 rst = 1'b1;
      go();

      // 2 hazard + 3 wait cycles, then async reset mid-MEMW
      ex_wb_en = 1'b1;
      ex_dest = 4'd3;
      src1 = 4'd3;
      go();
      go();
      clr();
      mem_req = 1'b1;
      go();
      go();
      go();
      #1;
`ifdef PIPE_STALL_COUNT_EN
      cmp("st_five", int'(stall_count), 5);
`endif
      cmp("st_memw", int'(state), 3);
      #1 rst = 1'b0;
      #1;
      cmp("ar_state", int'(state), 0);
      cmp("ar_hold", int'(pipe_hold), 0);
`ifdef PIPE_STALL_COUNT_EN
      cmp("ar_stall", int'(stall_count), 0);
`endif
      #3 rst = 1'b1;
      go();

      for (int i = 0; i < 3000; i++) begin
         src1 = 4'($urandom_range(0, 3));
         src2 = 4'($urandom_range(0, 3));
         ex_dest = 4'($urandom_range(0, 3));
         mem_dest = 4'($urandom_range(0, 3));
         two_src = 1'($urandom_range(0, 1));
         ex_wb_en = 1'($urandom_range(0, 1));
         mem_wb_en = 1'($urandom_range(0, 1));
         branch_taken_ex = ($urandom_range(0, 7) == 0);
         mem_req = ($urandom_range(0, 3) == 0);
         mem_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 299) == 0) begin
            #2 rst = 1'b0;
            #4 rst = 1'b1;
         end
         go();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
